// File: rtl/multdiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package multdiv_pkg;

    localparam int          MULTDIV_ITERATIONS = 32;
    localparam logic [31:0] DIV_ZERO_QUOTIENT  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        MULTU = 2'b00,
        MULT  = 2'b01,
        DIVU  = 2'b10,
        DIV   = 2'b11
    } multdiv_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } multdiv_state_t;

endpackage

// File: rtl/multdiv_iteration_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide.
module multdiv_iteration_step (
    input  logic        is_divide,
    input  logic [63:0] acc_in,
    input  logic [31:0] operand,
    output logic [63:0] acc_out
);

    logic [32:0] sum;
    logic [32:0] trial;
    logic [33:0] diff;

    // Multiply: {partial product, remaining multiplier bits}, right shift.
    // Divide: {partial remainder, dividend/quotient bits}, left shift.
    assign sum   = {1'b0, acc_in[63:32]} + (acc_in[0] ? {1'b0, operand} : 33'd0);
    assign trial = acc_in[63:31];
    assign diff  = {1'b0, trial} - {2'b00, operand};

    always_comb begin
        acc_out = {sum, acc_in[31:1]};
        if (is_divide) begin
            if (!diff[33])
                acc_out = {diff[31:0], acc_in[30:0], 1'b1};
            else
                acc_out = {trial[31:0], acc_in[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/hilo_multdiv_controller.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; fixed 33-edge latency.
// Signed MULT/DIV handling is built only when MULTDIV_SIGNED_EN is defined.
module hilo_multdiv_controller
    import multdiv_pkg::*;
#(
    parameter int ITERATIONS = MULTDIV_ITERATIONS
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_execute,
    input  logic [1:0]  operation_execute,
    input  logic [31:0] operand_a_execute,
    input  logic [31:0] operand_b_execute,
    input  logic        flush,
    output logic        busy,
    output logic        hi_lo_valid,
    output logic        divide_by_zero,
    output logic [31:0] ALU_HI_output,
    output logic [31:0] ALU_LO_output
);

    localparam logic [4:0] LAST_COUNT = 5'(ITERATIONS - 1);

    multdiv_state_t state, state_next;
    multdiv_op_t    op;
    logic [4:0]     count;
    logic [63:0]    acc, acc_step;
    logic [31:0]    opnd_b, a_raw;
    logic [31:0]    a_mag, b_mag;
    logic [31:0]    hi_result, lo_result;
    logic           is_div, b_zero, is_divide_req, accept;

    assign op            = multdiv_op_t'(operation_execute);
    assign is_divide_req = (op == DIVU) || (op == DIV);
    assign accept        = (state == IDLE) && start_execute && !flush;
    assign busy          = (state != IDLE);

`ifdef MULTDIV_SIGNED_EN
    logic op_signed, a_neg, b_neg, neg_lo, neg_hi;

    assign op_signed = (op == MULT) || (op == DIV);
    assign a_neg     = op_signed & operand_a_execute[31];
    assign b_neg     = op_signed & operand_b_execute[31];
    assign a_mag     = a_neg ? -operand_a_execute : operand_a_execute;
    assign b_mag     = b_neg ? -operand_b_execute : operand_b_execute;

    // neg_lo: product / quotient sign; neg_hi: remainder follows the dividend
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
        end else if (accept) begin
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
        end
    end
`else
    assign a_mag = operand_a_execute;
    assign b_mag = operand_b_execute;
`endif

    multdiv_iteration_step u_step (
        .is_divide (is_div),
        .acc_in    (acc),
        .operand   (opnd_b),
        .acc_out   (acc_step)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_execute) state_next = CALC;
                CALC:    if (count == LAST_COUNT) state_next = FINISH;
                FINISH:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        hi_result = acc[63:32];
        lo_result = acc[31:0];
`ifdef MULTDIV_SIGNED_EN
        if (!is_div) begin
            if (neg_lo) {hi_result, lo_result} = -acc;
        end else begin
            if (neg_lo) lo_result = -acc[31:0];
            if (neg_hi) hi_result = -acc[63:32];
        end
`endif
        // Zero divisor reports the raw dividend, not its magnitude
        if (is_div && b_zero) begin
            lo_result = DIV_ZERO_QUOTIENT;
            hi_result = a_raw;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count          <= '0;
            acc            <= '0;
            opnd_b         <= '0;
            a_raw          <= '0;
            is_div         <= 1'b0;
            b_zero         <= 1'b0;
            hi_lo_valid    <= 1'b0;
            divide_by_zero <= 1'b0;
            ALU_HI_output  <= '0;
            ALU_LO_output  <= '0;
        end else begin
            hi_lo_valid    <= 1'b0;
            divide_by_zero <= 1'b0;
            if (flush) begin
                count <= '0;
            end else begin
                case (state)
                    IDLE: if (start_execute) begin
                        acc    <= {32'd0, a_mag};
                        opnd_b <= b_mag;
                        a_raw  <= operand_a_execute;
                        is_div <= is_divide_req;
                        b_zero <= (operand_b_execute == 32'd0);
                        count  <= '0;
                    end
                    CALC: begin
                        acc   <= acc_step;
                        count <= (count == LAST_COUNT) ? 5'd0 : count + 5'd1;
                    end
                    FINISH: begin
                        ALU_HI_output  <= hi_result;
                        ALU_LO_output  <= lo_result;
                        hi_lo_valid    <= 1'b1;
                        divide_by_zero <= is_div & b_zero;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hilo_multdiv_controller.sv
// Scoreboard bench for hilo_multdiv_controller: arithmetic reference model, directed corners plus random ops.
module tb_hilo_multdiv_controller;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_execute = 1'b0;
    logic [1:0]  operation_execute = 2'b00;
    logic [31:0] operand_a_execute = '0;
    logic [31:0] operand_b_execute = '0;
    logic        flush = 1'b0;
    logic        busy, hi_lo_valid, divide_by_zero;
    logic [31:0] ALU_HI_output, ALU_LO_output;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   last_valid_cyc = -1;
    int   prev_valid_cyc = -1;
    exp_t sb[$];

    hilo_multdiv_controller dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start_execute     (start_execute),
        .operation_execute (operation_execute),
        .operand_a_execute (operand_a_execute),
        .operand_b_execute (operand_b_execute),
        .flush             (flush),
        .busy              (busy),
        .hi_lo_valid       (hi_lo_valid),
        .divide_by_zero    (divide_by_zero),
        .ALU_HI_output     (ALU_HI_output),
        .ALU_LO_output     (ALU_LO_output)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain SV arithmetic on the architectural values.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic        sgn;
        logic [63:0] p;
        longint      sa, sbv;
`ifdef MULTDIV_SIGNED_EN
        sgn = op[0];
`else
        sgn = 1'b0;
`endif
        e.dz = 1'b0;
        e.cyc = 0;
        if (!op[1]) begin
            if (sgn) p = 64'(longint'($signed(a)) * longint'($signed(b)));
            else     p = {32'd0, a} * {32'd0, b};
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'd0) begin
            e.lo = 32'hFFFF_FFFF;
            e.hi = a;
            e.dz = 1'b1;
        end else if (sgn) begin
            sa   = longint'($signed(a));
            sbv  = longint'($signed(b));
            e.lo = 32'(sa / sbv);
            e.hi = 32'(sa % sbv);
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    // Waits for IDLE (bounded), drives one request, optionally queues its expected result.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit expect_result);
        exp_t e;
        int   guard = 0;
        while (busy && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (busy) begin
            check("idle_timeout", 64'(busy), 64'd0);
            return;
        end
        start_execute = 1'b1;
        operation_execute = op;
        operand_a_execute = a;
        operand_b_execute = b;
        @(posedge clk); #1;
        start_execute = 1'b0;
        if (expect_result) begin
            e = model(op, a, b);
            e.cyc = cyc + 33;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((sb.size() != 0 || busy) && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (hi_lo_valid) begin
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_valid", 64'(hi_lo_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("hi", 64'(ALU_HI_output), 64'(e.hi));
                    check("lo", 64'(ALU_LO_output), 64'(e.lo));
                    check("dz", 64'(divide_by_zero), 64'(e.dz));
                    check("latency", 64'(cyc), 64'(e.cyc));
                    check("busy_at_valid", 64'(busy), 64'd0);
                end
            end else if (divide_by_zero) begin
                check("dz_without_valid", 64'(divide_by_zero), 64'd0);
            end
        end
    end

    initial begin
        exp_t tmp;
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(hi_lo_valid), 64'd0);
        check("rst_dz", 64'(divide_by_zero), 64'd0);
        check("rst_hilo", {ALU_HI_output, ALU_LO_output}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // MULTU max x max, with busy window E0..E33
        check("busy_before_req", 64'(busy), 64'd0);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 33; i++) begin
            check("busy_window", 64'(busy), 64'd1);
            @(posedge clk); #1;
        end
        check("busy_after_e33", 64'(busy), 64'd0);
        drain();

        issue(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b1);
        issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(2'b10, 32'h64, 32'd0, 1'b1);
        issue(2'b11, 32'hFFFF_FFF0, 32'd0, 1'b1);
        drain();

        // Flush: HI/LO preset to 0x11/0x22, then abort a DIVU mid-CALC
        issue(2'b10, 32'h451, 32'h20, 1'b1);
        drain();
        issue(2'b10, 32'd9, 32'd3, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        start_execute = 1'b1;
        operation_execute = 2'b00;
        operand_a_execute = 32'd7;
        operand_b_execute = 32'd7;
        @(posedge clk); #1;
        start_execute = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("busy_pre_flush", 64'(busy), 64'd1);
        flush = 1'b1;
        start_execute = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        start_execute = 1'b0;
        check("busy_after_flush", 64'(busy), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("hilo_after_flush", {ALU_HI_output, ALU_LO_output}, {32'h11, 32'h22});
        check("idle_after_flush", 64'(busy), 64'd0);

        // Async reset mid-CALC
        issue(2'b00, 32'd1234, 32'd5678, 1'b1);
        repeat (8) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        sb.delete();
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_hilo", {ALU_HI_output, ALU_LO_output}, 64'd0);
        check("async_rst_valid", 64'({hi_lo_valid, divide_by_zero}), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        issue(2'b00, 32'd2, 32'd3, 1'b1);
        issue(2'b00, 32'd4, 32'd5, 1'b1);
        drain();
        check("b2b_spacing", 64'(last_valid_cyc - prev_valid_cyc), 64'd34);

        // Random ops, mostly back-to-back
        for (int n = 0; n < 60; n++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            issue(op, pick(), pick(), 1'b1);
        end
        drain();

        tmp = model(2'b00, 32'd0, 32'd0);
        if (tmp.lo !== 32'd0) $display("note: model sanity");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
